bypass_pipe: RTL and testbench

Parametrised successor to the plain 8-bit pass-through. It carries a DATA_WIDTH-bit stream with a valid/ready handshake. A run-time mode selects one of two paths: a zero-latency combinational bypass, or a DEPTH-stage registered elastic pipeline. Mode changes take effect only after the pipeline has drained, so no beat is lost, duplicated or reordered. It sits between any producer/consumer pair that needs optional retiming on the path.

---
 rtl/bypass_pipe.sv | 107 ++++++++++
 tb/tb_bypass_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bypass_pipe.sv
// Valid/ready stream stage with a run-time choice between a combinational
// bypass and a DEPTH-stage elastic register pipeline; mode changes wait for drain.
module bypass_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Bypass_Req,
  input  logic [DATA_WIDTH-1:0]          Input_Data,
  input  logic                           Input_Valid,
  output logic                           Input_Ready,
  output logic [DATA_WIDTH-1:0]          Output_Data,
  output logic                           Output_Valid,
  input  logic                           Output_Ready,
  output logic                           Bypass_Active,
  output logic [$clog2(DEPTH+1)-1:0]     Fill_Count
);

  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH:0]        rdy;
  logic                  bypass_q, bypass_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  pending;
  logic                  in_xfer, out_xfer;

  assign pending = (Bypass_Req != bypass_q);

  // Ready ripples back from the output so bubbles anywhere in the chain collapse.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = Output_Ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !valid_q[k] | rdy[k+1];
    end
  end

  assign in_xfer  = !bypass_q & Input_Valid & rdy[0] & !pending;
  assign out_xfer = !bypass_q & valid_q[DEPTH-1] & Output_Ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
    end
    if (rdy[0]) begin
      valid_d[0] = in_xfer;
      if (in_xfer) begin
        data_d[0] = Input_Data;
      end
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (in_xfer && !out_xfer) begin
      fill_d = fill_q + FW'(1);
    end else if (out_xfer && !in_xfer) begin
      fill_d = fill_q - FW'(1);
    end
  end

  // The mode only flips once nothing is left in flight.
  always_comb begin
    bypass_d = bypass_q;
    if (pending && (fill_q == '0)) begin
      bypass_d = Bypass_Req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      bypass_q <= 1'b0;
      fill_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      bypass_q <= bypass_d;
      fill_q   <= fill_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign Input_Ready   = bypass_q ? (Output_Ready & !pending) : (rdy[0] & !pending);
  assign Output_Valid  = bypass_q ? (Input_Valid & !pending) : valid_q[DEPTH-1];
  assign Output_Data   = bypass_q ? Input_Data : data_q[DEPTH-1];
  assign Bypass_Active = bypass_q;
  assign Fill_Count    = fill_q;

endmodule

// File: tb/tb_bypass_pipe.sv
// Directed bench: three instances (DEPTH 2, 3, 4) exercised one at a time with
// hand-computed expectations checked by immediate assertions.
module tb_bypass_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] br  = '0;
  logic [2:0] iv  = '0;
  logic [2:0] orr = '0;
  logic [7:0] id [3];
  logic [2:0] ir, ov, ba;
  logic [7:0] od [3];
  logic [1:0] fc2, fc3;
  logic [2:0] fc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bypass_pipe #(.DATA_WIDTH(8), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .Bypass_Req(br[0]), .Input_Data(id[0]), .Input_Valid(iv[0]),
    .Input_Ready(ir[0]), .Output_Data(od[0]), .Output_Valid(ov[0]), .Output_Ready(orr[0]),
    .Bypass_Active(ba[0]), .Fill_Count(fc2));

  bypass_pipe #(.DATA_WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .Bypass_Req(br[1]), .Input_Data(id[1]), .Input_Valid(iv[1]),
    .Input_Ready(ir[1]), .Output_Data(od[1]), .Output_Valid(ov[1]), .Output_Ready(orr[1]),
    .Bypass_Active(ba[1]), .Fill_Count(fc3));

  bypass_pipe #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .Bypass_Req(br[2]), .Input_Data(id[2]), .Input_Valid(iv[2]),
    .Input_Ready(ir[2]), .Output_Data(od[2]), .Output_Valid(ov[2]), .Output_Ready(orr[2]),
    .Bypass_Active(ba[2]), .Fill_Count(fc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) id[i] = 8'h00;

    // Reset state
    #2;
    chk("rst_ov", {29'd0, ov}, 32'd0);
    chk("rst_ba", {29'd0, ba}, 32'd0);
    chk("rst_fc2", {30'd0, fc2}, 32'd0);
    chk("rst_fc4", {29'd0, fc4}, 32'd0);
    chk("rst_od0", {24'd0, od[0]}, 32'd0);
    #10;
    rst = 1'b0;
    #1;
    chk("rst_ir", {29'd0, ir}, 32'h7);

    // Registered streaming, DEPTH=3
    orr[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int e;
      iv[1] = (c < 16);
      id[1] = 8'(c + 1);
      #1;
      e = (c <= 3) ? c : ((c <= 16) ? 3 : 19 - c);
      chk("s_ir", {31'd0, ir[1]}, 32'd1);
      chk("s_ov", {31'd0, ov[1]}, (c >= 3 && c <= 18) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 18) chk("s_od", {24'd0, od[1]}, 32'(c - 2));
      chk("s_fc", {30'd0, fc3}, 32'(e));
      nxt();
    end
    iv[1] = 1'b0;

    // Backpressure, DEPTH=2
    orr[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'hA5; #1;
    chk("bp_ir_a", {31'd0, ir[0]}, 32'd1);
    nxt();
    id[0] = 8'h5A; #1;
    chk("bp_ir_b", {31'd0, ir[0]}, 32'd1);
    nxt();
    id[0] = 8'h3C; #1;
    chk("bp_ir_full", {31'd0, ir[0]}, 32'd0);
    chk("bp_fc", {30'd0, fc2}, 32'd2);
    chk("bp_ov", {31'd0, ov[0]}, 32'd1);
    chk("bp_od", {24'd0, od[0]}, 32'hA5);
    nxt();
    #1;
    chk("bp_hold_ir", {31'd0, ir[0]}, 32'd0);
    chk("bp_hold_od", {24'd0, od[0]}, 32'hA5);
    nxt();
    orr[0] = 1'b1; #1;
    chk("bp_ir_rise", {31'd0, ir[0]}, 32'd1);
    chk("bp_out1", {24'd0, od[0]}, 32'hA5);
    nxt();
    iv[0] = 1'b0; #1;
    chk("bp_out2", {24'd0, od[0]}, 32'h5A);
    chk("bp_fc_both", {30'd0, fc2}, 32'd2);
    nxt();
    #1;
    chk("bp_out3", {24'd0, od[0]}, 32'h3C);
    chk("bp_ov3", {31'd0, ov[0]}, 32'd1);
    chk("bp_fc1", {30'd0, fc2}, 32'd1);
    nxt();
    #1;
    chk("bp_empty_ov", {31'd0, ov[0]}, 32'd0);
    chk("bp_empty_fc", {30'd0, fc2}, 32'd0);

    // Drain-then-switch, DEPTH=4
    orr[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv[2] = 1'b1; id[2] = 8'((k + 1) * 17); #1;
      chk("dr_ir_fill", {31'd0, ir[2]}, 32'd1);
      nxt();
    end
    iv[2] = 1'b0; br[2] = 1'b1; #1;
    chk("dr_ir_pend", {31'd0, ir[2]}, 32'd0);
    chk("dr_ba0", {31'd0, ba[2]}, 32'd0);
    chk("dr_fc4", {29'd0, fc4}, 32'd4);
    nxt();
    #1;
    chk("dr_ba_hold", {31'd0, ba[2]}, 32'd0);
    chk("dr_fc_hold", {29'd0, fc4}, 32'd4);
    orr[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("dr_od", {24'd0, od[2]}, 32'((k + 1) * 17));
      chk("dr_ov", {31'd0, ov[2]}, 32'd1);
      chk("dr_ba", {31'd0, ba[2]}, 32'd0);
      chk("dr_ir", {31'd0, ir[2]}, 32'd0);
      nxt();
    end
    #1;
    chk("dr_empty_ov", {31'd0, ov[2]}, 32'd0);
    chk("dr_empty_fc", {29'd0, fc4}, 32'd0);
    chk("dr_ba_pre", {31'd0, ba[2]}, 32'd0);
    nxt();
    #1;
    chk("dr_ba_on", {31'd0, ba[2]}, 32'd1);

    // Bypass passthrough
    iv[2] = 1'b1; id[2] = 8'hC3; #1;
    chk("by_od", {24'd0, od[2]}, 32'hC3);
    chk("by_ov", {31'd0, ov[2]}, 32'd1);
    chk("by_ir", {31'd0, ir[2]}, 32'd1);
    chk("by_fc", {29'd0, fc4}, 32'd0);
    orr[2] = 1'b0; #1;
    chk("by_ir_bp", {31'd0, ir[2]}, 32'd0);
    nxt();
    // Back to registered: one cycle of no acceptance
    br[2] = 1'b0; orr[2] = 1'b1; #1;
    chk("bk_ir_pend", {31'd0, ir[2]}, 32'd0);
    chk("bk_ov_pend", {31'd0, ov[2]}, 32'd0);
    nxt();
    iv[2] = 1'b0; #1;
    chk("bk_ba_off", {31'd0, ba[2]}, 32'd0);
    chk("bk_ir", {31'd0, ir[2]}, 32'd1);

    // Aborted switch, DEPTH=2
    orr[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'h61; #1;
    chk("ab_ir_a", {31'd0, ir[0]}, 32'd1);
    nxt();
    id[0] = 8'h62; nxt();
    br[0] = 1'b1; orr[0] = 1'b1; id[0] = 8'h63; #1;
    chk("ab_ir_pend", {31'd0, ir[0]}, 32'd0);
    chk("ab_od1", {24'd0, od[0]}, 32'h61);
    nxt();
    br[0] = 1'b0; #1;
    chk("ab_ba", {31'd0, ba[0]}, 32'd0);
    chk("ab_ir_resume", {31'd0, ir[0]}, 32'd1);
    chk("ab_od2", {24'd0, od[0]}, 32'h62);
    chk("ab_fc1", {30'd0, fc2}, 32'd1);
    nxt();
    id[0] = 8'h64; #1;
    chk("ab_bubble", {31'd0, ov[0]}, 32'd0);
    chk("ab_ir2", {31'd0, ir[0]}, 32'd1);
    chk("ab_ba2", {31'd0, ba[0]}, 32'd0);
    nxt();
    iv[0] = 1'b0; #1;
    chk("ab_od3", {24'd0, od[0]}, 32'h63);
    chk("ab_fc2", {30'd0, fc2}, 32'd2);
    nxt();
    #1;
    chk("ab_od4", {24'd0, od[0]}, 32'h64);
    nxt();
    #1;
    chk("ab_empty", {31'd0, ov[0]}, 32'd0);
    chk("ab_fc0", {30'd0, fc2}, 32'd0);

    // Asynchronous reset mid-stream, DEPTH=2
    orr[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'h71; nxt();
    id[0] = 8'h72; nxt();
    iv[0] = 1'b0; #1;
    chk("mr_pre_fc", {30'd0, fc2}, 32'd2);
    chk("mr_pre_ov", {31'd0, ov[0]}, 32'd1);
    #2;
    rst = 1'b1; #1;
    chk("mr_ov", {31'd0, ov[0]}, 32'd0);
    chk("mr_fc", {30'd0, fc2}, 32'd0);
    chk("mr_ba", {29'd0, ba}, 32'd0);
    chk("mr_od", {24'd0, od[0]}, 32'd0);
    #3;
    rst = 1'b0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
